axi4_slave_ctrl: RTL and testbench

// AXI4 slave protocol engine that sits directly upstream of axi4_memory.

---
 rtl/axi4_slave_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_axi4_slave_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_ctrl.sv
// axi4_slave_ctrl: AXI4 INCR burst slave driving one single-port memory.
// Optional feature macro AXI_SLVERR_EN: out-of-range beats are suppressed and answered SLVERR.
module axi4_slave_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,
    parameter int AXI_ADDR_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    typedef enum logic [2:0] {IDLE, WR, WRESP, RD_ADDR, RD_DATA} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  wr_pri;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [7:0]            len;
    logic [7:0]            cnt;
    logic                  err;
    logic                  oor;
    logic                  aw_hi;
    logic                  ar_hi;
    logic                  aw_hs;
    logic                  ar_hs;
    logic                  w_hs;
    logic                  last;
    logic                  wlast_bad;

`ifdef AXI_SLVERR_EN
    assign aw_hi = |AWADDR[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2];
    assign ar_hi = |ARADDR[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2];
    logic unused_lsb;
    assign unused_lsb = ^{AWADDR[1:0], ARADDR[1:0]};
`else
    // Upper address bits alias onto the memory; everything answers OKAY.
    assign aw_hi = 1'b0;
    assign ar_hi = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{AWADDR[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2], AWADDR[1:0],
                           ARADDR[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2], ARADDR[1:0]};
`endif

    assign aw_hs     = AWVALID && AWREADY;
    assign ar_hs     = ARVALID && ARREADY;
    assign w_hs      = WVALID && WREADY;
    assign last      = (cnt == len);
    assign wlast_bad = (WLAST != last);
    assign addr_inc  = (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + 1'b1;
    assign mem_addr  = addr;
    assign mem_wdata = WDATA;
    // Out-of-range read beats return zero data with SLVERR.
    assign RDATA     = (RVALID && !RRESP[1]) ? mem_rdata : '0;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (aw_hs)      state_nxt = WR;
                else if (ar_hs) state_nxt = RD_ADDR;
            end
            WR:      if (w_hs && last) state_nxt = WRESP;
            WRESP:   if (BREADY) state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_DATA;
            RD_DATA: if (RREADY) state_nxt = last ? IDLE : RD_ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake readies and memory strobes, decoded from state
    always_comb begin
        AWREADY = 1'b0;
        ARREADY = 1'b0;
        WREADY  = 1'b0;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        if (!ARESET) begin
            unique case (state)
                IDLE: begin
                    AWREADY = AWVALID && (!ARVALID || wr_pri);
                    ARREADY = ARVALID && (!AWVALID || !wr_pri);
                end
                WR: begin
                    WREADY = 1'b1;
                    mem_en = WVALID && !oor;
                    mem_we = WVALID && !oor;
                end
                RD_ADDR: mem_en = !oor;
                default: ;
            endcase
        end
    end

    // Burst bookkeeping, arbitration pointer and registered B/R outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_pri <= 1'b1;
            addr   <= '0;
            len    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            oor    <= 1'b0;
            BVALID <= 1'b0;
            BRESP  <= 2'b00;
            RVALID <= 1'b0;
            RRESP  <= 2'b00;
            RLAST  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (AWVALID && ARVALID) wr_pri <= ~wr_pri;
                    if (aw_hs) begin
                        addr <= AWADDR[ADDR_WIDTH+1:2];
                        len  <= AWLEN;
                        cnt  <= '0;
                        err  <= 1'b0;
                        oor  <= aw_hi;
                    end else if (ar_hs) begin
                        addr <= ARADDR[ADDR_WIDTH+1:2];
                        len  <= ARLEN;
                        cnt  <= '0;
                        oor  <= ar_hi;
                    end
                end
                WR: begin
                    if (w_hs) begin
                        addr <= addr_inc;
                        cnt  <= cnt + 8'd1;
                        if (wlast_bad) err <= 1'b1;
                        if (last) begin
                            BVALID <= 1'b1;
                            BRESP  <= (err || wlast_bad || oor) ? 2'b10 : 2'b00;
                        end
                    end
                end
                WRESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        BRESP  <= 2'b00;
                    end
                end
                RD_ADDR: begin
                    RVALID <= 1'b1;
                    RLAST  <= last;
                    RRESP  <= oor ? 2'b10 : 2'b00;
                end
                RD_DATA: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        RLAST  <= 1'b0;
                        RRESP  <= 2'b00;
                        if (!last) begin
                            addr <= addr_inc;
                            cnt  <= cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_slave_ctrl.sv
// tb_axi4_slave_ctrl: directed bursts against a queue-based transaction model.
// Define AXI_SLVERR_EN to match an RTL build with the SLVERR feature.
module tb_axi4_slave_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int XW    = 16;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [XW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [XW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    axi4_slave_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AXI_ADDR_WIDTH(XW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Memory behind the slave: 1-cycle read latency, output held when idle
    logic [DW-1:0] mem_arr [DEPTH];
    logic          mem_init = 1'b0;
    always @(posedge ACLK) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= {16'hC0DE, 16'(i)};
            mem_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    // Model: expected memory image and expected transactions in order
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wexp_t;
    typedef struct { logic [DW-1:0] d; logic l; logic [1:0] r; } rexp_t;
    logic [DW-1:0] ref_mem [DEPTH];
    wexp_t         wq [$];
    logic [AW-1:0] raq [$];
    logic [1:0]    bq [$];
    rexp_t         rq [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event-missing-or-unexpected expected=none", nm);
    endtask

    function automatic logic is_oor(input logic [XW-1:0] a);
`ifdef AXI_SLVERR_EN
        return a >= 16'h1000;
`else
        return 1'b0;
`endif
    endfunction

    // Compare process: every memory strobe, B and R handshake against the model
    wexp_t ce;
    rexp_t cr;
    logic [AW-1:0] ca;
    always @(negedge ACLK) begin
        if (ARESET !== 1'b1) begin
            if (mem_en && mem_we) begin
                if (wq.size() == 0) flag("mem_write_unexpected");
                else begin
                    ce = wq.pop_front();
                    chk("mem_waddr", 64'(mem_addr), 64'(ce.a));
                    chk("mem_wdata", 64'(mem_wdata), 64'(ce.d));
                end
            end
            if (mem_en && !mem_we) begin
                if (raq.size() == 0) flag("mem_read_unexpected");
                else begin
                    ca = raq.pop_front();
                    chk("mem_raddr", 64'(mem_addr), 64'(ca));
                end
            end
            if (BVALID && BREADY) begin
                if (bq.size() == 0) flag("b_unexpected");
                else chk("bresp", 64'(BRESP), 64'(bq.pop_front()));
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) flag("r_unexpected");
                else begin
                    cr = rq.pop_front();
                    chk("rdata", 64'(RDATA), 64'(cr.d));
                    chk("rlast", 64'(RLAST), 64'(cr.l));
                    chk("rresp", 64'(RRESP), 64'(cr.r));
                end
            end
        end
    end

    task automatic do_reset();
        ARESET = 1'b1;
        @(posedge ACLK);
        #1 ARESET = 1'b0;
    endtask

    task automatic do_write(input logic [XW-1:0] a, input int len, input int lastb,
                            input logic [DW-1:0] base, output int t_hs,
                            output logic [1:0] resp);
        logic oor;
        logic ok;
        int   w;
        oor = is_oor(a);
        for (int i = 0; i <= len; i++) begin
            w = (int'(a >> 2) + i) % DEPTH;
            if (!oor) begin
                wq.push_back('{a: AW'(w), d: base + DW'(i)});
                ref_mem[w] = base + DW'(i);
            end
        end
        bq.push_back((oor || lastb != len) ? 2'b10 : 2'b00);
        AWADDR  = a;
        AWLEN   = 8'(len);
        AWVALID = 1'b1;
        t_hs    = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (AWREADY) begin
                t_hs = cyc;
                break;
            end
        end
        if (t_hs < 0) flag("aw_handshake_timeout");
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            WDATA  = base + DW'(i);
            WLAST  = (i == lastb);
            WVALID = 1'b1;
            ok     = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge ACLK);
                if (WREADY) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) flag("w_handshake_timeout");
            @(posedge ACLK);
            #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        chk("bvalid_after_last_w", 64'(BVALID), 64'd1);
        resp = 2'b11;
        ok   = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (BVALID) begin
                resp = BRESP;
                ok   = 1'b1;
                break;
            end
        end
        if (!ok) flag("b_timeout");
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_read(input logic [XW-1:0] a, input int len, input int stall,
                           output int t_hs, output logic [DW-1:0] d0,
                           output logic [1:0] r0);
        logic          oor;
        logic          ok;
        logic [DW-1:0] cd;
        logic          cl;
        int            w;
        oor = is_oor(a);
        for (int i = 0; i <= len; i++) begin
            w = (int'(a[AW+1:2]) + i) % DEPTH;
            if (!oor) raq.push_back(AW'(w));
            rq.push_back('{d: oor ? '0 : ref_mem[w], l: (i == len), r: oor ? 2'b10 : 2'b00});
        end
        ARADDR  = a;
        ARLEN   = 8'(len);
        ARVALID = 1'b1;
        t_hs    = -1;
        d0      = '0;
        r0      = 2'b11;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (ARREADY) begin
                t_hs = cyc;
                break;
            end
        end
        if (t_hs < 0) flag("ar_handshake_timeout");
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            RREADY = (i != stall);
            ok     = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge ACLK);
                if (RVALID) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) flag("r_timeout");
            if (i == 0) begin
                chk("r_first_latency", 64'(cyc - t_hs), 64'd2);
                d0 = RDATA;
                r0 = RRESP;
            end
            if (i == stall) begin
                cd = RDATA;
                cl = RLAST;
                repeat (5) begin
                    @(negedge ACLK);
                    chk("stall_rvalid", 64'(RVALID), 64'd1);
                    chk("stall_rdata", 64'(RDATA), 64'(cd));
                    chk("stall_rlast", 64'(RLAST), 64'(cl));
                    chk("stall_mem_en", 64'(mem_en), 64'd0);
                end
                @(posedge ACLK);
                #1 RREADY = 1'b1;
            end
            @(posedge ACLK);
            #1;
        end
        RREADY = 1'b1;
    endtask

    int            t_aw;
    int            t_ar;
    logic [1:0]    resp;
    logic [DW-1:0] d0;
    logic [1:0]    r0;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = {16'hC0DE, 16'(i)};
        ARESET  = 1'b1;
        AWADDR  = '0;
        AWLEN   = '0;
        AWVALID = 1'b1;
        WDATA   = '0;
        WLAST   = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b1;
        ARADDR  = '0;
        ARLEN   = '0;
        ARVALID = 1'b1;
        RREADY  = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_bresp", 64'(BRESP), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);
        chk("rst_rlast", 64'(RLAST), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        AWVALID = 1'b0;
        ARVALID = 1'b0;
        ARESET  = 1'b0;
        @(posedge ACLK);
        #1;

        // Basic 4-beat write then read back
        do_write(16'h0010, 3, 3, 32'hA0, t_aw, resp);
        chk("t1_bresp_lit", 64'(resp), 64'd0);
        for (int i = 0; i < 4; i++)
            chk("t1_mem_word", 64'(mem_arr[4 + i]), 64'(32'hA0 + i));
        do_read(16'h0010, 3, -1, t_ar, d0, r0);
        chk("t2_rdata0_lit", 64'(d0), 64'h0A0);

        // Simultaneous requests: write first after reset, then read first
        do_reset();
        fork
            do_write(16'h0100, 1, 1, 32'h3000, t_aw, resp);
            do_read(16'h0200, 1, -1, t_ar, d0, r0);
        join
        chk("t3_write_first", 64'(t_aw < t_ar), 64'd1);
        chk("t3_rdata0_lit", 64'(d0), 64'hC0DE0080);
        fork
            do_write(16'h0108, 1, 1, 32'h3100, t_aw, resp);
            do_read(16'h0208, 1, -1, t_ar, d0, r0);
        join
        chk("t3_read_first", 64'(t_ar < t_aw), 64'd1);

        // Stall on third beat
        do_read(16'h0010, 3, 2, t_ar, d0, r0);

        // Early WLAST: all beats written, SLVERR
        do_write(16'h0040, 3, 1, 32'h5000, t_aw, resp);
        chk("t5_bresp_lit", 64'(resp), 64'd2);
        chk("t5_mem_last_beat", 64'(mem_arr[19]), 64'h5003);

        // Word address wrap inside a burst
        do_write(16'h0FFC, 1, 1, 32'hB0, t_aw, resp);
        chk("t5_wrap_hi", 64'(mem_arr[1023]), 64'h0B0);
        chk("t5_wrap_lo", 64'(mem_arr[0]), 64'h0B1);
        do_read(16'h0FFC, 1, -1, t_ar, d0, r0);

        // Address above the memory
        do_read(16'h1000, 0, -1, t_ar, d0, r0);
`ifdef AXI_SLVERR_EN
        chk("t6_rdata_lit", 64'(d0), 64'h0);
        chk("t6_rresp_lit", 64'(r0), 64'd2);
`else
        chk("t6_rdata_lit", 64'(d0), 64'h0B1);
        chk("t6_rresp_lit", 64'(r0), 64'd0);
`endif

        // Reset in the middle of a write burst drops the remaining beats
        wq.push_back('{a: AW'(192), d: 32'h7000});
        wq.push_back('{a: AW'(193), d: 32'h7001});
        ref_mem[192] = 32'h7000;
        ref_mem[193] = 32'h7001;
        AWADDR  = 16'h0300;
        AWLEN   = 8'd3;
        AWVALID = 1'b1;
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            WDATA  = 32'h7000 + DW'(i);
            WVALID = 1'b1;
            @(posedge ACLK);
            #1;
        end
        WVALID = 1'b0;
        do_reset();
        chk("mid_rst_wready", 64'(WREADY), 64'd0);
        chk("mid_rst_bvalid", 64'(BVALID), 64'd0);
        WDATA  = 32'h7777;
        WVALID = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            chk("mid_rst_w_dropped", 64'(WREADY), 64'd0);
        end
        @(posedge ACLK);
        #1 WVALID = 1'b0;
        do_read(16'h0300, 3, -1, t_ar, d0, r0);
        chk("mid_rst_word194", 64'(mem_arr[194]), 64'hC0DE00C2);

        repeat (3) @(posedge ACLK);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("raq_drained", 64'(raq.size()), 64'd0);
        chk("bq_drained", 64'(bq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
